// File: rtl/player_pkg.sv
// ============================================================================
// Module : player_pkg
// Brief  : Shared types and constants for the player hit/respawn controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package player_pkg;

  typedef enum logic [1:0] {
    ALIVE     = 2'd0,
    EXPLODING = 2'd1,
    RESPAWN   = 2'd2,
    DEAD      = 2'd3
  } player_state_t;

  localparam int FRAME_CNT_W = 8;

  // Saturate at all-ones so an over-long phase can never wrap back to frame 0.
  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frame_timer.sv
// ============================================================================
// Module : frame_timer
// Brief  : Saturating per-frame counter; flags the SOF that closes the phase.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_timer
  import player_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   start_of_frame,
  input  logic [FRAME_CNT_W-1:0] target,
  output logic                   done,
  output logic [FRAME_CNT_W-1:0] count_nxt
);

  logic [FRAME_CNT_W-1:0] r_count;

  assign done      = start_of_frame && (r_count == target);
  assign count_nxt = clr            ? '0 :
                     start_of_frame ? sat_inc(r_count) : r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_count <= '0;
    else        r_count <= count_nxt;
  end

endmodule

`default_nettype wire

// File: rtl/player_hit_ctrl.sv
// ============================================================================
// Module : player_hit_ctrl
// Brief  : Turns raw collision hits into explosion pulses and sequences the
//          player through explode, blinking respawn, alive and game over.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module player_hit_ctrl
  import player_pkg::*;
#(
  parameter int EXPLODE_FRAMES = 32,
  parameter int INVULN_FRAMES  = 120,
  parameter int BLINK_LOG2     = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_of_frame,
  input  logic       collision,
  input  logic [2:0] lives_left,
  output logic       explosion,
  output logic       exploding,
  output logic       invulnerable,
  output logic       player_visible,
  output logic       respawn_req,
  output logic       game_over
);

  localparam logic [FRAME_CNT_W-1:0] c_explode_last = FRAME_CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [FRAME_CNT_W-1:0] c_invuln_last  = FRAME_CNT_W'(INVULN_FRAMES - 1);

  player_state_t          r_state;
  logic                   r_hit_latch;
  logic                   r_explosion;
  logic                   r_exploding;
  logic                   r_invulnerable;
  logic                   r_visible;
  logic                   r_respawn_req;
  logic                   r_game_over;

  logic                   w_hit_seen;
  logic                   w_timing;
  logic                   w_clr;
  logic                   w_done;
  logic [FRAME_CNT_W-1:0] w_target;
  logic [FRAME_CNT_W-1:0] w_count_nxt;

  // A hit on the SOF cycle itself still belongs to the frame that is closing.
  assign w_hit_seen = r_hit_latch | collision;
  assign w_timing   = (r_state == EXPLODING) || (r_state == RESPAWN);
  assign w_clr      = !w_timing || w_done;
  assign w_target   = (r_state == RESPAWN) ? c_invuln_last : c_explode_last;

  frame_timer u_frame_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (w_clr),
    .start_of_frame (start_of_frame),
    .target         (w_target),
    .done           (w_done),
    .count_nxt      (w_count_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ALIVE;
      r_hit_latch    <= 1'b0;
      r_explosion    <= 1'b0;
      r_exploding    <= 1'b0;
      r_invulnerable <= 1'b0;
      r_visible      <= 1'b1;
      r_respawn_req  <= 1'b0;
      r_game_over    <= 1'b0;
    end else begin
      r_explosion   <= 1'b0;
      r_respawn_req <= 1'b0;
      r_hit_latch   <= (r_state == ALIVE) && !start_of_frame && w_hit_seen;
      case (r_state)
        ALIVE: begin
          if (start_of_frame) begin
            // An exhausted life count wins over a hit: no pulse into an empty counter.
            if (lives_left == 3'd0) begin
              r_state     <= DEAD;
              r_game_over <= 1'b1;
              r_visible   <= 1'b0;
            end else if (w_hit_seen) begin
              r_state     <= EXPLODING;
              r_explosion <= 1'b1;
              r_exploding <= 1'b1;
              r_visible   <= 1'b1;
            end
          end
        end
        EXPLODING: begin
          if (w_done) begin
            r_exploding <= 1'b0;
            if (lives_left == 3'd0) begin
              r_state     <= DEAD;
              r_game_over <= 1'b1;
              r_visible   <= 1'b0;
            end else begin
              r_state        <= RESPAWN;
              r_respawn_req  <= 1'b1;
              r_invulnerable <= 1'b1;
              r_visible      <= 1'b1;
            end
          end
        end
        RESPAWN: begin
          if (w_done) begin
            r_state        <= ALIVE;
            r_invulnerable <= 1'b0;
            r_visible      <= 1'b1;
          end else begin
            r_visible <= ~w_count_nxt[BLINK_LOG2];
          end
        end
        default: begin
          r_state <= DEAD;
        end
      endcase
    end
  end

  assign explosion      = r_explosion;
  assign exploding      = r_exploding;
  assign invulnerable   = r_invulnerable;
  assign player_visible = r_visible;
  assign respawn_req    = r_respawn_req;
  assign game_over      = r_game_over;

endmodule

`default_nettype wire

// File: tb/tb_player_hit_ctrl.sv
// ============================================================================
// Module : tb_player_hit_ctrl
// Brief  : Self-checking bench for player_hit_ctrl against a frame-level model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_player_hit_ctrl;

  localparam int EXPLODE = 32;
  localparam int INVULN  = 120;
  localparam int BLOG2   = 3;
  localparam int BLINK   = 1 << BLOG2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sof;
  logic       collision;
  logic [2:0] lives_left;
  logic       explosion, exploding, invulnerable, player_visible, respawn_req, game_over;

  int n_vec = 0;
  int n_err = 0;
  int n_expl = 0;
  int lives_base;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  player_hit_ctrl #(
    .EXPLODE_FRAMES (EXPLODE),
    .INVULN_FRAMES  (INVULN),
    .BLINK_LOG2     (BLOG2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_of_frame (sof),
    .collision      (collision),
    .lives_left     (lives_left),
    .explosion      (explosion),
    .exploding      (exploding),
    .invulnerable   (invulnerable),
    .player_visible (player_visible),
    .respawn_req    (respawn_req),
    .game_over      (game_over)
  );

  // Lives counter stand-in: decremented by the model's own explosion pulses.
  assign lives_left = 3'((lives_base > n_expl) ? ((lives_base - n_expl > 7) ? 7 : lives_base - n_expl) : 0);

  // Model: phase 0 alive, 1 exploding, 2 respawning, 3 dead; m_left = frames remaining.
  int   m_phase, m_left;
  logic m_hit, e_explosion, e_respawn;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0; m_left <= 0; m_hit <= 1'b0;
      e_explosion <= 1'b0; e_respawn <= 1'b0;
    end else begin
      e_explosion <= 1'b0;
      e_respawn   <= 1'b0;
      m_hit       <= 1'b0;
      case (m_phase)
        0: begin
          m_hit <= !sof && (m_hit || collision);
          if (sof) begin
            if (lives_left == 0) m_phase <= 3;
            else if (m_hit || collision) begin
              m_phase <= 1; m_left <= EXPLODE; e_explosion <= 1'b1;
            end
          end
        end
        1: if (sof) begin
          if (m_left == 1) begin
            if (lives_left == 0) m_phase <= 3;
            else begin m_phase <= 2; m_left <= INVULN; e_respawn <= 1'b1; end
          end else m_left <= m_left - 1;
        end
        2: if (sof) begin
          if (m_left == 1) m_phase <= 0;
          else m_left <= m_left - 1;
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) if (e_explosion) n_expl <= n_expl + 1;

  logic x_vis;
  assign x_vis = (m_phase == 0) || (m_phase == 1) ||
                 (m_phase == 2 && (((INVULN - m_left) / BLINK) % 2) == 0);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("explosion",    32'(explosion),      32'(e_explosion));
    check("exploding",    32'(exploding),      32'(m_phase == 1));
    check("invulnerable", 32'(invulnerable),   32'(m_phase == 2));
    check("visible",      32'(player_visible), 32'(x_vis));
    check("respawn_req",  32'(respawn_req),    32'(e_respawn));
    check("game_over",    32'(game_over),      32'(m_phase == 3));
  end

  // Pulse and blink observers, compared against hand-derived literals below.
  int c_expl = 0, c_resp = 0, c_tog = 0;
  logic prev_vis = 1'b1;
  always @(negedge clk) begin
    if (explosion)   c_expl <= c_expl + 1;
    if (respawn_req) c_resp <= c_resp + 1;
    if (player_visible !== prev_vis) c_tog <= c_tog + 1;
    prev_vis <= player_visible;
  end

  task automatic drive(input logic s, input logic c);
    sof = s; collision = c;
    @(posedge clk); #1;
  endtask

  // mode: 0 none, 1 held high, 2 sparse random, 3 SOF cycle only, 4 5-cycle mid-frame burst
  task automatic run_frames(input int n, input int mode);
    for (int f = 0; f < n; f++) begin
      int len;
      len = (mode == 4) ? 10 : int'($urandom_range(3, 6));
      for (int c = 0; c < len; c++) begin
        logic col;
        case (mode)
          0:       col = 1'b0;
          1:       col = 1'b1;
          2:       col = ($urandom_range(0, 15) == 0);
          3:       col = (c == 0);
          default: col = (c >= 2 && c < 7);
        endcase
        drive(c == 0, col);
      end
    end
  endtask

  task automatic do_reset();
    sof = 1'b0; collision = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_explosion", 32'(explosion),      0);
    check("rst_exploding", 32'(exploding),      0);
    check("rst_invuln",    32'(invulnerable),   0);
    check("rst_visible",   32'(player_visible), 1);
    check("rst_respawn",   32'(respawn_req),    0);
    check("rst_game_over", 32'(game_over),      0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  int d_expl, d_resp, d_tog;

  initial begin
    rst_n = 1'b0; sof = 1'b0; collision = 1'b0; lives_base = 3;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("init_visible", 32'(player_visible), 1);
    check("init_game_over", 32'(game_over), 0);

    // Single hit, then invulnerable respawn with collision held
    lives_base = n_expl + 3;
    run_frames(1, 0);
    d_expl = c_expl; d_resp = c_resp; d_tog = c_tog;
    run_frames(1, 4);
    check("t1_no_early_expl", 32'(c_expl - d_expl), 0);
    run_frames(1, 0);
    check("t1_one_expl", 32'(c_expl - d_expl), 1);
    check("t1_exploding", 32'(exploding), 1);
    run_frames(31, 0);
    check("t1_still_expl", 32'(exploding), 1);
    check("t1_no_resp_yet", 32'(c_resp - d_resp), 0);
    run_frames(1, 0);
    check("t1_resp_pulse", 32'(c_resp - d_resp), 1);
    check("t1_invuln", 32'(invulnerable), 1);
    run_frames(119, 1);
    check("t2_invuln_held", 32'(invulnerable), 1);
    check("t2_no_expl", 32'(c_expl - d_expl), 1);
    run_frames(1, 1);
    check("t2_alive", 32'(invulnerable), 0);
    check("t2_visible", 32'(player_visible), 1);
    check("t2_blink_toggles", 32'(c_tog - d_tog), 14);
    check("t2_no_expl_end", 32'(c_expl - d_expl), 1);

    // Last life
    do_reset();
    lives_base = n_expl + 1;
    d_expl = c_expl; d_resp = c_resp;
    run_frames(1, 4);
    run_frames(1, 0);
    check("t3_lives_zero", 32'(lives_left), 0);
    run_frames(32, 0);
    check("t3_game_over", 32'(game_over), 1);
    check("t3_invisible", 32'(player_visible), 0);
    check("t3_no_resp", 32'(c_resp - d_resp), 0);
    run_frames(3, 1);
    check("t3_dead_sticky", 32'(game_over), 1);
    check("t3_one_expl", 32'(c_expl - d_expl), 1);

    // SOF-coincident hit
    do_reset();
    lives_base = n_expl + 3;
    run_frames(1, 0);
    d_expl = c_expl;
    run_frames(1, 3);
    check("t4_expl", 32'(c_expl - d_expl), 1);
    run_frames(2, 0);
    check("t4_no_second", 32'(c_expl - d_expl), 1);

    // Reset at exploding frame 10
    do_reset();
    lives_base = n_expl + 3;
    run_frames(1, 4);
    run_frames(1, 0);
    run_frames(10, 0);
    check("t5_exploding_before", 32'(exploding), 1);
    do_reset();
    check("t5_alive_vis", 32'(player_visible), 1);
    check("t5_alive_expl", 32'(exploding), 0);

    // Forced game over
    do_reset();
    lives_base = n_expl + 3;
    run_frames(2, 0);
    lives_base = n_expl;
    d_expl = c_expl;
    run_frames(1, 0);
    check("t6_game_over", 32'(game_over), 1);
    check("t6_no_expl", 32'(c_expl - d_expl), 0);

    // Randomized segments
    for (int it = 0; it < 25; it++) begin
      do_reset();
      lives_base = n_expl + int'($urandom_range(1, 7));
      for (int s = 0; s < 5; s++) begin
        if ($urandom_range(0, 7) == 0) lives_base = n_expl + int'($urandom_range(0, 2));
        run_frames(int'($urandom_range(1, 50)), int'($urandom_range(0, 3)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
